// File: rtl/fp32_pkg.sv
// Shared types and constants for the single-precision multiply controller:
// FSM encoding, IEEE constants, flag bit positions and operand classification.
package fp32_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPECIAL,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_NORM,
        ST_ROUND,
        ST_OUT
    } state_t;

    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    // Bit positions inside flags = {invalid, overflow, underflow, inexact, timeout}
    localparam int FLAG_INVALID   = 4;
    localparam int FLAG_OVERFLOW  = 3;
    localparam int FLAG_UNDERFLOW = 2;
    localparam int FLAG_INEXACT   = 1;
    localparam int FLAG_TIMEOUT   = 0;

    typedef struct packed {
        logic is_nan;
        logic is_inf;
        logic is_zero;
    } fp_class_t;

    // Denormals (exponent 0) classify as zero: the unit flushes them.
    function automatic fp_class_t classify(input logic [30:0] x);
        fp_class_t c;
        c.is_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        c.is_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        c.is_zero = (x[30:23] == 8'h00);
        return c;
    endfunction

endpackage

// File: rtl/fp32_mul_ctrl_if.sv
// Operand, multiplier and result handshake bundle for fp32_mul_ctrl.
// slave = the controller's view, master = the surrounding environment.
interface fp32_mul_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        mult_start;
    logic [23:0] mult_a;
    logic [23:0] mult_b;
    logic        mult_ready;
    logic [47:0] mult_product;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  flags;

    modport slave (
        input  in_valid, a, b, mult_ready, mult_product, out_ready,
        output in_ready, mult_start, mult_a, mult_b, out_valid, result, flags
    );

    modport master (
        output in_valid, a, b, mult_ready, mult_product, out_ready,
        input  in_ready, mult_start, mult_a, mult_b, out_valid, result, flags
    );
endinterface

// File: rtl/fp32_round_rne.sv
// Round-to-nearest-even on a normalized 23-bit fraction plus guard/sticky,
// then exponent range check against the single-precision limits.
module fp32_round_rne (
    input  logic              [22:0] mant,
    input  logic                     guard,
    input  logic                     sticky,
    input  logic signed       [9:0]  exp_in,
    output logic              [22:0] mant_out,
    output logic              [7:0]  exp_field,
    output logic                     inexact,
    output logic                     overflow,
    output logic                     underflow
);
    logic [23:0]       sum;
    logic signed [9:0] exp_adj;

    always_comb begin
        sum       = {1'b0, mant} + 24'(guard & (sticky | mant[0]));
        // A carry out of the fraction means it wrapped to zero: bump the exponent.
        exp_adj   = exp_in + {9'd0, sum[23]};
        mant_out  = sum[22:0];
        exp_field = exp_adj[7:0];
        overflow  = (exp_adj >= 10'sd255);
        underflow = (exp_adj <= 10'sd0);
        inexact   = guard | sticky | overflow | underflow;
    end
endmodule

// File: rtl/fp32_mul_ctrl.sv
// IEEE-754 single-precision multiply unit: unpacks operands, drives an external
// 24-bit shift-add mantissa multiplier, then normalizes/rounds the product.
module fp32_mul_ctrl #(
    parameter int WAIT_LIMIT = 64,
    parameter int BIAS       = 127
) (
    input  logic           clk,
    input  logic           rst,
    fp32_mul_ctrl_if.slave bus
);
    import fp32_pkg::*;

    localparam int          WD_W          = $clog2(WAIT_LIMIT + 1);
    localparam logic [4:0]  TIMEOUT_FLAGS = 5'((1 << FLAG_INVALID) | (1 << FLAG_TIMEOUT));

    state_t            state_reg, state_next;
    logic              sign_reg;
    logic signed [9:0] exp_reg;
    fp_class_t         class_a_reg, class_b_reg;
    logic [23:0]       mult_a_reg, mult_b_reg;
    logic [47:0]       product_reg;
    logic [22:0]       mant_reg;
    logic              guard_reg, sticky_reg;
    logic [31:0]       result_reg;
    logic [4:0]        flags_reg;
    logic [WD_W-1:0]   watchdog_reg;

    fp_class_t         class_a, class_b;
    logic              special_in, wd_expire, timeout_hit;
    logic              in_ready_c, out_valid_c, mult_start_c;
    logic signed [9:0] exp_sum;
    logic [22:0]       rnd_mant;
    logic [7:0]        rnd_exp;
    logic              rnd_inexact, rnd_overflow, rnd_underflow;
    logic [31:0]       special_result, round_result;
    logic [4:0]        special_flags, round_flags;

    assign class_a     = classify(bus.a[30:0]);
    assign class_b     = classify(bus.b[30:0]);
    assign special_in  = (|class_a) | (|class_b);
    assign exp_sum     = 10'(bus.a[30:23]) + 10'(bus.b[30:23]) - 10'(BIAS);
    assign wd_expire   = (watchdog_reg == WD_W'(WAIT_LIMIT - 1));
    // Completion in WAIT_DONE takes priority over a coincident watchdog expiry.
    assign timeout_hit = wd_expire && ((state_reg == ST_WAIT_BUSY) ||
                                       (state_reg == ST_WAIT_DONE && !bus.mult_ready));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next   = state_reg;
        in_ready_c   = 1'b0;
        out_valid_c  = 1'b0;
        mult_start_c = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_next = special_in ? ST_SPECIAL : ST_START;
            end
            ST_SPECIAL: state_next = ST_OUT;
            ST_START: begin
                if (bus.mult_ready) begin
                    mult_start_c = 1'b1;
                    state_next   = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (timeout_hit)          state_next = ST_OUT;
                else if (!bus.mult_ready) state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.mult_ready)   state_next = ST_NORM;
                else if (timeout_hit) state_next = ST_OUT;
            end
            ST_NORM:  state_next = ST_ROUND;
            ST_ROUND: state_next = ST_OUT;
            ST_OUT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        special_result = {sign_reg, 31'd0};
        special_flags  = '0;
        if (class_a_reg.is_nan | class_b_reg.is_nan |
            (class_a_reg.is_inf & class_b_reg.is_zero) |
            (class_a_reg.is_zero & class_b_reg.is_inf)) begin
            special_result              = QNAN;
            special_flags[FLAG_INVALID] = 1'b1;
        end else if (class_a_reg.is_inf | class_b_reg.is_inf) begin
            special_result = {sign_reg, POS_INF[30:0]};
        end
    end

    fp32_round_rne u_round (
        .mant      (mant_reg),
        .guard     (guard_reg),
        .sticky    (sticky_reg),
        .exp_in    (exp_reg),
        .mant_out  (rnd_mant),
        .exp_field (rnd_exp),
        .inexact   (rnd_inexact),
        .overflow  (rnd_overflow),
        .underflow (rnd_underflow)
    );

    always_comb begin
        round_flags                 = '0;
        round_flags[FLAG_OVERFLOW]  = rnd_overflow;
        round_flags[FLAG_UNDERFLOW] = rnd_underflow;
        round_flags[FLAG_INEXACT]   = rnd_inexact;
        if (rnd_overflow)       round_result = {sign_reg, POS_INF[30:0]};
        else if (rnd_underflow) round_result = {sign_reg, 31'd0};
        else                    round_result = {sign_reg, rnd_exp, rnd_mant};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_reg     <= 1'b0;
            exp_reg      <= '0;
            class_a_reg  <= '0;
            class_b_reg  <= '0;
            mult_a_reg   <= '0;
            mult_b_reg   <= '0;
            product_reg  <= '0;
            mant_reg     <= '0;
            guard_reg    <= 1'b0;
            sticky_reg   <= 1'b0;
            result_reg   <= '0;
            flags_reg    <= '0;
            watchdog_reg <= '0;
        end else begin
            if (state_reg == ST_WAIT_BUSY || state_reg == ST_WAIT_DONE)
                watchdog_reg <= watchdog_reg + WD_W'(1);
            else
                watchdog_reg <= '0;

            case (state_reg)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        sign_reg    <= bus.a[31] ^ bus.b[31];
                        exp_reg     <= exp_sum;
                        class_a_reg <= class_a;
                        class_b_reg <= class_b;
                        // Operands only reach the multiplier on the normal path.
                        if (!special_in) begin
                            mult_a_reg <= {1'b1, bus.a[22:0]};
                            mult_b_reg <= {1'b1, bus.b[22:0]};
                        end
                    end
                end
                ST_SPECIAL: begin
                    result_reg <= special_result;
                    flags_reg  <= special_flags;
                end
                ST_WAIT_BUSY, ST_WAIT_DONE: begin
                    if (timeout_hit) begin
                        result_reg <= QNAN;
                        flags_reg  <= TIMEOUT_FLAGS;
                    end else if (state_reg == ST_WAIT_DONE && bus.mult_ready) begin
                        product_reg <= bus.mult_product;
                    end
                end
                ST_NORM: begin
                    if (product_reg[47]) begin
                        mant_reg   <= product_reg[46:24];
                        guard_reg  <= product_reg[23];
                        sticky_reg <= |product_reg[22:0];
                        exp_reg    <= exp_reg + 10'sd1;
                    end else begin
                        mant_reg   <= product_reg[45:23];
                        guard_reg  <= product_reg[22];
                        sticky_reg <= |product_reg[21:0];
                    end
                end
                ST_ROUND: begin
                    result_reg <= round_result;
                    flags_reg  <= round_flags;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.mult_start = mult_start_c;
    assign bus.mult_a     = mult_a_reg;
    assign bus.mult_b     = mult_b_reg;
    assign bus.result     = result_reg;
    assign bus.flags      = flags_reg;

endmodule

// File: tb/tb_fp32_mul_ctrl.sv
// Bench for fp32_mul_ctrl: behavioural multiplier stub plus an arithmetic
// reference model of single-precision multiply (FTZ, RNE).
module tb_fp32_mul_ctrl;
    localparam int WAIT_LIMIT  = 64;
    localparam int MULT_CYCLES = 27;
    localparam int NORMAL_LAT  = MULT_CYCLES + 4;
    localparam int SPECIAL_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   stuck_mode = 1'b0;
    int   busy_cnt;
    int   start_cnt = 0;
    logic [23:0] seen_mult_a, seen_mult_b;

    fp32_mul_ctrl_if bus();

    fp32_mul_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .BIAS(127)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Multiplier stub: drops ready after a start, returns the product MULT_CYCLES later.
    // In stuck mode it ignores start and keeps ready high.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.mult_ready   <= 1'b1;
            bus.mult_product <= '0;
            busy_cnt         <= 0;
        end else if (bus.mult_ready) begin
            if (bus.mult_start && !stuck_mode) begin
                bus.mult_ready <= 1'b0;
                busy_cnt       <= MULT_CYCLES - 1;
                seen_mult_a    <= bus.mult_a;
                seen_mult_b    <= bus.mult_b;
            end
        end else if (busy_cnt == 1) begin
            bus.mult_ready   <= 1'b1;
            busy_cnt         <= 0;
            bus.mult_product <= 48'(bus.mult_a) * 48'(bus.mult_b);
        end else begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (bus.mult_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, expv);
        end
    endtask

    // Reference: exact integer product, rounded by comparing the discarded part to one half.
    function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output logic [4:0] f, output bit special);
        int          ex, ey, e, sh;
        bit          sgn, xn, yn, xi, yi, xz, yz, inexact;
        longint      p, q, rem, half;
        ex  = int'(x[30:23]);
        ey  = int'(y[30:23]);
        sgn = x[31] ^ y[31];
        xn  = (ex == 255) && (x[22:0] != 0);
        yn  = (ey == 255) && (y[22:0] != 0);
        xi  = (ex == 255) && (x[22:0] == 0);
        yi  = (ey == 255) && (y[22:0] == 0);
        xz  = (ex == 0);
        yz  = (ey == 0);
        f   = 5'b00000;
        special = xn || yn || xi || yi || xz || yz;
        if (xn || yn || (xi && yz) || (xz && yi)) begin
            r = 32'h7FC00000;
            f = 5'b10000;
        end else if (xi || yi) begin
            r = {sgn, 8'hFF, 23'd0};
        end else if (xz || yz) begin
            r = {sgn, 31'd0};
        end else begin
            p  = longint'(x[22:0] + (1 << 23)) * longint'(y[22:0] + (1 << 23));
            e  = ex + ey - 127;
            sh = 23;
            if (p >= (64'sd1 <<< 47)) begin
                sh = 24;
                e  = e + 1;
            end
            q    = p >>> sh;
            rem  = p - (q <<< sh);
            half = 64'sd1 <<< (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'sd1 <<< 24)) begin
                q = q >>> 1;
                e = e + 1;
            end
            inexact = (rem != 0);
            if (e >= 255) begin
                r = {sgn, 8'hFF, 23'd0};
                f = 5'b01010;
            end else if (e <= 0) begin
                r = {sgn, 31'd0};
                f = 5'b00110;
            end else begin
                r = {sgn, 8'(e), 23'(q)};
                f = {3'b000, inexact, 1'b0};
            end
        end
    endfunction

    function automatic logic [31:0] rand_operand();
        int          kind;
        logic        s;
        logic [22:0] fr;
        logic [7:0]  ex;
        kind = $urandom_range(0, 11);
        s    = 1'($urandom);
        fr   = 23'($urandom);
        case (kind)
            0:       ex = 8'h00;
            1:       begin ex = 8'hFF; fr = '0; end
            2:       begin ex = 8'hFF; fr = fr | 23'd1; end
            3, 4:    ex = 8'($urandom_range(200, 254));
            5, 6:    ex = 8'($urandom_range(1, 60));
            default: ex = 8'($urandom_range(100, 154));
        endcase
        return {s, ex, fr};
    endfunction

    // One full transaction; exp_lat = 0 skips the latency/start-count checks.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                          input logic [31:0] exp_r, input logic [4:0] exp_f,
                          input int exp_lat, input int hold);
        int waited = 0;
        int lat;
        int starts_before;
        @(negedge clk);
        while (!bus.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        starts_before = start_cnt;
        bus.in_valid = 1'b1;
        bus.a = ta;
        bus.b = tbv;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        if (exp_lat > 0) begin
            check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
            check_eq({tag, "_starts"}, 32'(start_cnt - starts_before),
                     (exp_lat == SPECIAL_LAT) ? 32'd0 : 32'd1);
        end
        for (int i = 0; i < hold; i++) begin
            check_eq({tag, "_hold_result"}, bus.result, exp_r);
            check_eq({tag, "_hold_flags"}, 32'(bus.flags), 32'(exp_f));
            check_eq({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            check_eq({tag, "_hold_out_valid"}, 32'(bus.out_valid), 32'd1);
            @(negedge clk);
        end
        check_eq({tag, "_result"}, bus.result, exp_r);
        check_eq({tag, "_flags"}, 32'(bus.flags), 32'(exp_f));
        $display("op %s a=%08h b=%08h result=%08h flags=%05b latency=%0d",
                 tag, ta, tbv, bus.result, bus.flags, lat);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq({tag, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
        check_eq({tag, "_post_out_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
        int          hold;
    } vec_t;

    vec_t dir_vecs [5];

    initial begin
        logic [31:0] ra, rb, rr;
        logic [4:0]  rf;
        bit          rs;
        int          seen_out;

        dir_vecs[0] = '{32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000, NORMAL_LAT, 0};
        dir_vecs[1] = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00010, NORMAL_LAT, 10};
        dir_vecs[2] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 5'b01010, NORMAL_LAT, 0};
        dir_vecs[3] = '{32'h00800000, 32'h3F000000, 32'h00000000, 5'b00110, NORMAL_LAT, 0};
        dir_vecs[4] = '{32'h7F800000, 32'h80000000, 32'h7FC00000, 5'b10000, SPECIAL_LAT, 0};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_mult_start", 32'(bus.mult_start), 32'd0);
        check_eq("rst_mult_a", 32'(bus.mult_a), 32'd0);
        check_eq("rst_mult_b", 32'(bus.mult_b), 32'd0);
        check_eq("rst_result", bus.result, 32'd0);
        check_eq("rst_flags", 32'(bus.flags), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_op($sformatf("dir%0d", i), dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].r,
                   dir_vecs[i].f, dir_vecs[i].lat, dir_vecs[i].hold);
            if (i == 0) begin
                check_eq("dir0_mult_a", 32'(seen_mult_a), 32'h00C00000);
                check_eq("dir0_mult_b", 32'(seen_mult_b), 32'h00800000);
            end
        end

        stuck_mode = 1'b1;
        run_op("timeout", 32'h3FC00000, 32'h40000000, 32'h7FC00000, 5'b10001, 0, 0);
        stuck_mode = 1'b0;

        // Reset while the multiplier is busy: nothing may come out afterwards.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = 32'h3FC00000;
        bus.b = 32'h40000000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        seen_out = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen_out++;
        end
        check_eq("midrst_no_out", 32'(seen_out), 32'd0);
        check_eq("midrst_idle_in_ready", 32'(bus.in_ready), 32'd1);
        $display("op midrst aborted out_valid_cycles=%0d", seen_out);
        run_op("after_rst", 32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000, NORMAL_LAT, 0);

        for (int i = 0; i < 40; i++) begin
            ra = rand_operand();
            rb = rand_operand();
            ref_mul(ra, rb, rr, rf, rs);
            run_op($sformatf("rnd%0d", i), ra, rb, rr, rf, rs ? SPECIAL_LAT : NORMAL_LAT,
                   int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp32_mul_ctrl.md
Name: fp32_mul_ctrl

Overview:
- Wraps the 24-bit shift-add mantissa multiplier to form an IEEE-754 single-precision multiply unit.
- Accepts two operands over a valid/ready handshake and unpacks them.
- Sequences the multiplier's start/ready protocol, then normalizes and rounds the 48-bit product with round-to-nearest-even.
- Presents the packed result and exception flags over a valid/ready handshake.

Parameters:
- WAIT_LIMIT, 64, max cycles to wait for the multiplier to return ready before aborting.
- BIAS, 127, exponent bias.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operands a/b valid
- in_ready  out  1  block accepts operands
- a  in  32  IEEE single operand A
- b  in  32  IEEE single operand B
- mult_start  out  1  start pulse to mantissa multiplier
- mult_a  out  24  mantissa A {1,frac}
- mult_b  out  24  mantissa B {1,frac}
- mult_ready  in  1  multiplier idle/done
- mult_product  in  48  multiplier product
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  32  packed IEEE result
- flags  out  5  {invalid, overflow, underflow, inexact, timeout}

Behaviour:
- Reset (rst=0, async): state IDLE; in_ready=1, out_valid=0, mult_start=0, mult_a=mult_b=0, result=0, flags=0, watchdog=0.
- States: IDLE, SPECIAL, START, WAIT_BUSY, WAIT_DONE, NORM, ROUND, OUT.
- IDLE: in_ready=1. On in_valid, capture a/b, sign=a[31]^b[31], exponent sum ea+eb-BIAS into a 10-bit signed register. in_ready drops the next cycle.
- Denormal inputs (exp=0) are flushed to zero (FTZ).
- Special detection, on the accept cycle: any NaN, inf, or zero operand -> SPECIAL. Otherwise -> START.
- SPECIAL (1 cycle), then OUT:
  - NaN operand or inf*0 -> 0x7FC00000, invalid=1.
  - inf*x -> signed inf.
  - zero*x -> signed zero.
  - No multiplier activity.
- START: mult_start=1 for exactly one cycle, asserted only when mult_ready=1; otherwise stay in START. mult_a/mult_b stay stable from START until leaving WAIT_DONE.
- WAIT_BUSY: wait for mult_ready=0.
- WAIT_DONE: wait for mult_ready=1, then capture mult_product.
- Watchdog counts cycles spent in WAIT_BUSY+WAIT_DONE. On reaching WAIT_LIMIT -> OUT with result 0x7FC00000, timeout=1, invalid=1.
- NORM:
  - If P[47]=1: mant=P[46:24], g=P[23], s=|P[22:0], exp+1.
  - Else: mant=P[45:23], g=P[22], s=|P[21:0].
- ROUND (RNE): increment when g & (s | mant[0]). Mantissa carry-out -> mant=0, exp+1. inexact=g|s.
- Exponent range after ROUND:
  - exp>=255 -> signed inf, overflow=1, inexact=1.
  - exp<=0 -> signed zero, underflow=1, inexact=1.
- OUT: out_valid=1. result/flags are held stable until out_ready=1. Transfer cycle -> IDLE with in_ready=1 the next cycle.
- Latency, accept to out_valid:
  - Special path: 2 cycles.
  - Normal path: multiplier time + 4 control cycles. Normal multiplier time is 27 cycles.
- No new operand is accepted while busy; in_ready=0 outside IDLE.
- in_valid and out handshake never overlap; the block is single-entry.
- Reset mid-operation aborts everything immediately, with no out_valid. The multiplier shares the reset.

Decomposition:
- Package fp32_pkg: state encoding, BIAS, QNAN=32'h7FC00000, POS_INF=32'h7F800000, flag bit indices, and a classify function returning {is_nan, is_inf, is_zero}.
- One natural sub-module, fp32_round_rne: purely combinational. Takes normalized mantissa, g, s, and exp; returns rounded mantissa, adjusted exp, and inexact/overflow/underflow.
- The FSM, watchdog, and registers stay in fp32_mul_ctrl.

Test Plan:
- a=0x3FC00000 (1.5), b=0x40000000 (2.0) -> multiplier sees 0xC00000/0x800000; result=0x40400000, flags=0.
- a=b=0x3F800001 -> result=0x3F800002, inexact=1 (RNE of 1+2^-22+2^-46).
- a=0x7F000000, b=0x40000000 -> result=0x7F800000, overflow=1, inexact=1.
- a=0x00800000, b=0x3F000000 -> result=0x00000000, underflow=1.
- a=0x7F800000, b=0x80000000 -> result=0x7FC00000, invalid=1, out_valid 2 cycles after accept, mult_start never asserted.
- Stub multiplier holds mult_ready=1 forever after start, WAIT_LIMIT=64 -> result=0x7FC00000, timeout=1.
- out_ready held low 10 cycles -> result stable and in_ready=0 throughout.
- rst pulsed mid-WAIT_DONE -> out_valid=0, in_ready=1.
